// File: rtl/fa_pipe_pkg.sv
// Shared constants and helpers for the pipelined segmented add/subtract unit.
// Saturation constants are consumed only when FA_PIPE_SAT_EN is defined.
package fa_pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 16;
  localparam int MAX_W     = 1024;

  function automatic int n_stages(int w, int s);
    return (s < 1) ? 1 : w / s;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w - 1) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i == w - 1) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fa_seg_stage.sv
// One SEG-bit segment of the ripple pipeline: adds a segment with carry-in
// and registers partial sum, carry-out and the beat valid bit.
module fa_seg_stage
  import fa_pipe_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           i_v,
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_c,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_v
);

  logic [SEG:0]   w_add;
  logic [SEG-1:0] r_sum;
  logic           r_cout;
  logic           r_v;

  assign w_add = {1'b0, i_a} + {1'b0, i_b}
               + {{SEG{1'b0}}, i_c};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_v    <= 1'b0;
    end else if (en) begin
      r_sum  <= w_add[SEG-1:0];
      r_cout <= w_add[SEG];
      r_v    <= i_v;
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_v    = r_v;

endmodule

// File: rtl/fa_pipe_addsub.sv
// Pipelined WIDTH-bit add/subtract, one SEG-bit segment per stage, with
// valid/ready flow control; FA_PIPE_SAT_EN enables signed saturation.
module fa_pipe_addsub
  import fa_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  input  logic             SAT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout,
  output logic             OVF
);

  localparam int STAGES = n_stages(WIDTH, SEG);
  localparam int L      = STAGES - 1;
  localparam int SEGD   = (SEG < 1) ? 1 : SEG;

  if ((SEG < 1) || ((WIDTH % SEGD) != 0)) begin : g_bad_cfg
    $error("fa_pipe_addsub: WIDTH must be a multiple of SEG >= 1");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_beff;
  logic             w_c0;
  logic [WIDTH-1:0] w_raw;
  logic             r_xm;

  assign w_en     = !OUT_VALID || OUT_READY;
  assign IN_READY = w_en;
  assign w_beff   = SUB ? ~B : B;
  assign w_c0     = SUB | Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k * SEG;
    // w_ra/w_rb: operand bits not yet consumed, segment k at the bottom
    logic [RW-1:0]        w_ra;
    logic [RW-1:0]        w_rb;
    logic                 w_ci;
    logic                 w_vi;
    logic [SEG-1:0]       w_sum;
    logic                 w_co;
    logic                 w_vo;
    logic [(k+1)*SEG-1:0] w_lo;
`ifdef FA_PIPE_SAT_EN
    logic                 w_sat;
`endif

    if (k == 0) begin : g_head
      assign w_ra = A;
      assign w_rb = w_beff;
      assign w_ci = w_c0;
      assign w_vi = IN_VALID;
      assign w_lo = w_sum;
`ifdef FA_PIPE_SAT_EN
      assign w_sat = SAT;
`endif
    end else begin : g_tail
      logic [RW-1:0]      r_ra;
      logic [RW-1:0]      r_rb;
      logic [k*SEG-1:0]   r_fw;
`ifdef FA_PIPE_SAT_EN
      logic               r_sat;
`endif

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_ra <= '0;
          r_rb <= '0;
          r_fw <= '0;
`ifdef FA_PIPE_SAT_EN
          r_sat <= 1'b0;
`endif
        end else if (w_en) begin
          r_ra <= g_st[k-1].w_ra[RW+SEG-1:SEG];
          r_rb <= g_st[k-1].w_rb[RW+SEG-1:SEG];
          r_fw <= g_st[k-1].w_lo;
`ifdef FA_PIPE_SAT_EN
          r_sat <= g_st[k-1].w_sat;
`endif
        end
      end

      assign w_ra = r_ra;
      assign w_rb = r_rb;
      assign w_ci = g_st[k-1].w_co;
      assign w_vi = g_st[k-1].w_vo;
      assign w_lo = {w_sum, r_fw};
`ifdef FA_PIPE_SAT_EN
      assign w_sat = r_sat;
`endif
    end

    fa_seg_stage #(.SEG(SEG)) u_seg (
      .clk    (CLK),
      .rst    (RST),
      .en     (w_en),
      .i_v    (w_vi),
      .i_a    (w_ra[SEG-1:0]),
      .i_b    (w_rb[SEG-1:0]),
      .i_c    (w_ci),
      .o_sum  (w_sum),
      .o_cout (w_co),
      .o_v    (w_vo)
    );
  end

  // a^b of the MSB, kept so the carry into the MSB can be recovered
  always_ff @(posedge CLK) begin
    if (RST)
      r_xm <= 1'b0;
    else if (w_en)
      r_xm <= g_st[L].w_ra[SEG-1] ^ g_st[L].w_rb[SEG-1];
  end

  assign w_raw     = g_st[L].w_lo;
  assign Cout      = g_st[L].w_co;
  assign OUT_VALID = g_st[L].w_vo;
  assign OVF       = r_xm ^ w_raw[WIDTH-1] ^ Cout;

`ifdef FA_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  logic r_sat_o;

  always_ff @(posedge CLK) begin
    if (RST)
      r_sat_o <= 1'b0;
    else if (w_en)
      r_sat_o <= g_st[L].w_sat;
  end

  // on overflow the carry-out equals the common operand sign
  assign SUM = (r_sat_o && OVF) ? (Cout ? SAT_MIN : SAT_MAX) : w_raw;
`else
  logic w_unused;

  assign w_unused = SAT;
  assign SUM      = w_raw;
`endif

endmodule

// File: tb/tb_fa_pipe_addsub.sv
// Scoreboard bench for fa_pipe_addsub (WIDTH=32, SEG=16); expected saturation
// results follow FA_PIPE_SAT_EN when the bench is built with it.
module tb_fa_pipe_addsub;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Cin = 1'b0;
  logic        SUB = 1'b0;
  logic        SAT = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] SUM;
  logic        Cout;
  logic        OVF;

  logic [33:0] q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_out = 0;
  int          n0;
  int          idx;
  int          ncyc;
  bit          acc;

  fa_pipe_addsub dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .SUB       (SUB),
    .SAT       (SAT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SUM       (SUM),
    .Cout      (Cout),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [33:0] model(logic [31:0] a, logic [31:0] b,
                                        logic c, logic s, logic t);
    logic [31:0] be;
    logic        c0;
    logic [32:0] r;
    logic [31:0] res;
    logic        ov;
    be  = s ? ~b : b;
    c0  = s ? 1'b1 : c;
    r   = {1'b0, a} + {1'b0, be} + {32'd0, c0};
    ov  = (a[31] == be[31]) && (r[31] != a[31]);
    res = r[31:0];
`ifdef FA_PIPE_SAT_EN
    if (t && ov) res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    if (t && ov) res = r[31:0];
`endif
    return {r[32], ov, res};
  endfunction

  task automatic check(input string tag, input logic [33:0] got,
                       input logic [33:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(output bit a);
    #2;
    a = 1'b0;
    if (RST) begin
      q.delete();
    end else begin
      check("in_ready", 34'(IN_READY), 34'(!(OUT_VALID && !OUT_READY)));
      if (OUT_VALID) begin
        n_vec++;
        assert (q.size() > 0) else begin
          n_bad++;
          $error("FAIL spurious_out got=%h exp=none", SUM);
        end
        if (q.size() > 0) begin
          check("result", {Cout, OVF, SUM}, q[0]);
          if (OUT_READY) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (IN_VALID && IN_READY) begin
        q.push_back(model(A, B, Cin, SUB, SAT));
        a = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic s, input logic t);
    bit ok;
    ok = 1'b0;
    A = a; B = b; Cin = c; SUB = s; SAT = t;
    IN_VALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) cyc(ok);
    IN_VALID = 1'b0;
    check("send_accept", 34'(ok), 34'd1);
  endtask

  task automatic wait_out(input string tag, input logic [33:0] exp);
    bit a;
    for (int i = 0; i < 10 && !OUT_VALID; i++) cyc(a);
    check({tag, "_valid"}, 34'(OUT_VALID), 34'd1);
    check(tag, {Cout, OVF, SUM}, exp);
    cyc(a);
  endtask

  task automatic drain();
    bit a;
    OUT_READY = 1'b1;
    IN_VALID = 1'b0;
    for (int i = 0; i < 50 && q.size() > 0; i++) cyc(a);
    check("drain_empty", 34'(q.size()), 34'd0);
  endtask

  initial begin
    // reset state
    cyc(acc);
    cyc(acc);
    RST = 1'b0;
    check("rst_valid", 34'(OUT_VALID), 34'd0);
    check("rst_sum", {Cout, OVF, SUM}, 34'd0);
    check("rst_ready", 34'(IN_READY), 34'd1);

    // latency and carry across the segment boundary
    send(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    check("lat1_valid", 34'(OUT_VALID), 34'd0);
    cyc(acc);
    check("lat2_valid", 34'(OUT_VALID), 34'd1);
    check("seg_carry", {Cout, OVF, SUM}, {2'b00, 32'h0001_0000});
    cyc(acc);

    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    wait_out("wrap", {2'b10, 32'h0});

    send(32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    wait_out("sub_neg", {2'b00, 32'hFFFF_FFFE});

    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
`ifdef FA_PIPE_SAT_EN
    wait_out("sat_pos", {2'b01, 32'h7FFF_FFFF});
`else
    wait_out("sat_pos", {2'b01, 32'h8000_0000});
`endif

    send(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1);
`ifdef FA_PIPE_SAT_EN
    wait_out("sat_neg", {2'b11, 32'h8000_0000});
`else
    wait_out("sat_neg", {2'b11, 32'h7FFF_FFFF});
`endif

    send(32'h1234_5678, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    wait_out("cin_add", {2'b00, 32'h1234_567A});
    drain();

    // stream with a two-cycle downstream stall
    n0 = n_out;
    idx = 0;
    for (int t = 0; t < 16; t++) begin
      OUT_READY = !(t == 3 || t == 4);
      IN_VALID = (idx < 4);
      A = 32'(idx + 1);
      B = 32'd10;
      Cin = 1'b0; SUB = 1'b0; SAT = 1'b0;
      #1;
      if (t == 3 || t == 4) begin
        check("stall_ready", 34'(IN_READY), 34'd0);
        check("stall_valid", 34'(OUT_VALID), 34'd1);
        check("stall_hold", {Cout, OVF, SUM}, {2'b00, 32'd12});
      end
      cyc(acc);
      if (acc) idx++;
    end
    drain();
    check("stream_count", 34'(n_out - n0), 34'd4);

    // reset with two beats in flight
    OUT_READY = 1'b0;
    A = 32'd100; B = 32'd1; IN_VALID = 1'b1;
    cyc(acc);
    A = 32'd200;
    cyc(acc);
    A = 32'd300;
    RST = 1'b1;
    cyc(acc);
    RST = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    check("flush_valid", 34'(OUT_VALID), 34'd0);
    check("flush_sum", {Cout, OVF, SUM}, 34'd0);
    check("flush_ready", 34'(IN_READY), 34'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(acc);
      check("flush_quiet", 34'(OUT_VALID), 34'd0);
    end
    send(32'd7, 32'd8, 1'b0, 1'b0, 1'b0);
    wait_out("post_rst", {2'b00, 32'd15});

    // random traffic with random backpressure
    idx = 0;
    ncyc = 0;
    while (idx < 30 && ncyc < 400) begin
      if (!IN_VALID || acc) begin
        A = $urandom;
        B = $urandom;
        Cin = 1'($urandom_range(0, 1));
        SUB = 1'($urandom_range(0, 1));
        SAT = 1'($urandom_range(0, 1));
        IN_VALID = 1'($urandom_range(0, 3) != 0);
      end
      OUT_READY = 1'($urandom_range(0, 3) != 0);
      cyc(acc);
      if (acc) idx++;
      ncyc++;
    end
    check("rand_accepted", 34'(idx), 34'd30);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
